// File: rtl/i2c_cfg_pkg.sv
// Shared types for the camera-decoder register loader: FSM states and table entries.
package i2c_cfg_pkg;

    typedef enum logic [2:0] {
        STARTUP,
        LOAD,
        ISSUE,
        WAIT_DONE,
        GAP,
        FINISH,
        FAIL
    } cfg_state_t;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] val;
    } cfg_entry_t;

    localparam logic [7:0] ADV_ADDR = 8'h40;

endpackage

// File: rtl/config_rom.sv
// Register table for the video decoder: index -> (register, value).
// Latency: combinational. Backpressure: none, pure lookup.
// Indices past NUM_REGS-1 read back as zero.
module config_rom
    import i2c_cfg_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4
) (
    input  logic [IDX_W-1:0] index,
    output cfg_entry_t       entry
);

    logic [7:0] idx8;
    cfg_entry_t tbl;

    assign idx8 = 8'(index);

    always_comb begin
        tbl = '0;
        case (idx8)
            8'd0:  tbl = '{reg_addr: 8'h00, val: 8'h04};
            8'd1:  tbl = '{reg_addr: 8'h04, val: 8'h57};
            8'd2:  tbl = '{reg_addr: 8'h17, val: 8'h41};
            8'd3:  tbl = '{reg_addr: 8'h31, val: 8'h02};
            8'd4:  tbl = '{reg_addr: 8'h3D, val: 8'hA2};
            8'd5:  tbl = '{reg_addr: 8'h3E, val: 8'h6A};
            8'd6:  tbl = '{reg_addr: 8'h3F, val: 8'hA0};
            8'd7:  tbl = '{reg_addr: 8'h0E, val: 8'h80};
            8'd8:  tbl = '{reg_addr: 8'h55, val: 8'h81};
            8'd9:  tbl = '{reg_addr: 8'h0E, val: 8'h00};
            8'd10: tbl = '{reg_addr: 8'h1D, val: 8'h40};
            8'd11: tbl = '{reg_addr: 8'h27, val: 8'h58};
            8'd12: tbl = '{reg_addr: 8'h2B, val: 8'hE1};
            8'd13: tbl = '{reg_addr: 8'h37, val: 8'h01};
            8'd14: tbl = '{reg_addr: 8'h0F, val: 8'h00};
            8'd15: tbl = '{reg_addr: 8'h8F, val: 8'h50};
            default: tbl = '0;
        endcase
    end

    assign entry = ({1'b0, idx8} < 9'(NUM_REGS)) ? tbl : '0;

endmodule

// File: rtl/i2c_config_sequencer.sv
// Power-up loader: walks config_rom issuing one i2c write per entry, with retry/timeout.
// Latency: STARTUP_CYCLES+2 to first start; GAP_CYCLES+2 plus transaction time between starts.
// Backpressure: waits for i2c_done (or timeout) before moving on; go honoured only when idle.
module i2c_config_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int  NUM_REGS       = 16,
    parameter int  STARTUP_CYCLES = 50000,
    parameter int  GAP_CYCLES     = 1000,
    parameter int  TIMEOUT_CYCLES = 20000,
    parameter int  MAX_RETRY      = 3,
    localparam int IDX_W          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             i2c_done,
    input  logic             i2c_nack,
    output logic             start,
    output logic             read,
    output logic [7:0]       reg_dest,
    output logic [7:0]       data_to_send,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] index
);

    localparam int CNT_MAX0 = (STARTUP_CYCLES > GAP_CYCLES) ? STARTUP_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > TIMEOUT_CYCLES) ? CNT_MAX0 : TIMEOUT_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] STUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

    cfg_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [RTY_W-1:0] retry;
    cfg_entry_t       rom_entry;

    config_rom #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_rom (
        .index (index),
        .entry (rom_entry)
    );

    assign read = 1'b0;

    // start is set on the ISSUE exit edge so reg_dest/data_to_send have settled a cycle earlier
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= STARTUP;
            cnt          <= '0;
            retry        <= '0;
            index        <= '0;
            start        <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            busy         <= 1'b1;
            reg_dest     <= '0;
            data_to_send <= '0;
        end else begin
            start <= 1'b0;
            case (state)
                STARTUP: begin
                    if (cnt == STUP_LAST) begin
                        cnt   <= '0;
                        state <= LOAD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOAD: begin
                    reg_dest     <= rom_entry.reg_addr;
                    data_to_send <= rom_entry.val;
                    state        <= ISSUE;
                end
                ISSUE: begin
                    start <= 1'b1;
                    cnt   <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // done wins over a coincident timeout
                    if (i2c_done && !i2c_nack) begin
                        cnt   <= '0;
                        retry <= '0;
                        if (index == LAST_IDX) begin
                            state <= FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            index <= index + 1'b1;
                            state <= GAP;
                        end
                    end else if (i2c_done || cnt == TMO_LAST) begin
                        cnt <= '0;
                        if (retry < RTY_MAX) begin
                            retry <= retry + 1'b1;
                            state <= GAP;
                        end else begin
                            state <= FAIL;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= LOAD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FINISH, FAIL: begin
                    if (go) begin
                        index <= '0;
                        retry <= '0;
                        cnt   <= '0;
                        done  <= 1'b0;
                        error <= 1'b0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                default: state <= STARTUP;
            endcase
        end
    end

endmodule

// File: doc/i2c_config_sequencer.md
# i2c_config_sequencer

Power-up register loader for the BT656 camera front end. It sits directly upstream of `i2c_master` and walks a fixed table of (register, value) pairs, issuing one I2C write per entry with retry and timeout handling. It reports completion or failure to the rest of the design. Its `reg_dest`/`data_to_send` outputs are the values shown on the HEX debug display.

## Interface
Parameters:
- `NUM_REGS`, 16: number of table entries. Range 1..256.
- `STARTUP_CYCLES`, 50000: idle cycles after reset release before the first write, for decoder power-up.
- `GAP_CYCLES`, 1000: idle cycles between consecutive writes.
- `TIMEOUT_CYCLES`, 20000: maximum cycles to wait for `i2c_done` after a `start`.
- `MAX_RETRY`, 3: additional attempts per entry after the first attempt fails.

Ports:
- `clk` in 1: the `i2c_master` clock, taken from the `clock_divider` output. This is the single clock domain.
- `reset` in 1: asynchronous, active-low.
- `go` in 1: one-cycle pulse. Restarts the sequence from entry 0. Honoured only in `FINISH` or `FAIL`.
- `i2c_done` in 1: one-cycle pulse from the master when a transaction ends.
- `i2c_nack` in 1: NACK flag from the master. Valid only in the cycle `i2c_done` is high.
- `start` out 1: one-cycle transaction request to the master.
- `read` out 1: constant 0. The block performs writes only.
- `reg_dest` out 8: register address of the current entry.
- `data_to_send` out 8: register value of the current entry.
- `busy` out 1: high in every state except `FINISH` and `FAIL`.
- `done` out 1: high only in `FINISH`.
- `error` out 1: high only in `FAIL`.
- `index` out `$clog2(NUM_REGS)`, minimum width 1: index of the current entry.

## Operation
States: `STARTUP`, `LOAD`, `ISSUE`, `WAIT_DONE`, `GAP`, `FINISH`, `FAIL`.

- Reset asserted:
  - state = `STARTUP`; `index`, retry count and cycle counter = 0.
  - `start`, `done`, `error`, `reg_dest`, `data_to_send` = 0; `busy` = 1.
- `STARTUP`: count `STARTUP_CYCLES`, then go to `LOAD`.
- `LOAD`: latch the entry at `index` from `config_rom` into `reg_dest`/`data_to_send`, then go to `ISSUE`.
- `ISSUE`: drive `start` = 1 for this one cycle, clear the cycle counter, then go to `WAIT_DONE`.
- `WAIT_DONE`:
  - On `i2c_done` with `i2c_nack` = 0: success. Clear the retry count. If `index == NUM_REGS-1`, go to `FINISH`; otherwise increment `index` and go to `GAP`.
  - On `i2c_done` with `i2c_nack` = 1, or when the counter reaches `TIMEOUT_CYCLES`: failure. If retry count < `MAX_RETRY`, increment it and go to `GAP`, keeping the same `index`. Otherwise go to `FAIL` with `index` frozen on the failing entry.
- `GAP`: count `GAP_CYCLES`, then go to `LOAD`.
- `FINISH` / `FAIL`: hold all outputs. `go` clears `index` and the retry count and enters `LOAD` directly, with no startup delay.
- Boundaries:
  - `i2c_done` arriving in the same cycle the timeout is reached counts as done; the NACK check still applies.
  - `i2c_done` outside `WAIT_DONE` is ignored.
  - `go` outside `FINISH`/`FAIL` is ignored.
  - `index` never wraps.
  - Reset asserted mid-transaction aborts immediately. `start` must not be re-asserted until the `STARTUP` delay has elapsed again.

## Timing
- `reg_dest`/`data_to_send` change only on the `LOAD` exit edge. They are stable for at least one cycle before `start` rises and remain stable until the next `LOAD`.
- `start` is exactly one cycle wide. There is at most one `start` per `WAIT_DONE` visit.
- `start` to the next `start`: at least transaction time + `GAP_CYCLES` + 2 cycles.
- First `start` follows reset release by exactly `STARTUP_CYCLES` + 2 cycles.
- `done`/`error` rise in the cycle after the qualifying `i2c_done` or timeout. They are registered outputs.

## Structure
- Package `i2c_cfg_pkg` holds:
  - the `cfg_state_t` enum;
  - the `cfg_entry_t` packed struct `{reg[7:0], val[7:0]}`;
  - the device address constant `ADV_ADDR = 8'h40`.
- Sub-module `config_rom`: combinational lookup of `index` to `cfg_entry_t`. Entries past `NUM_REGS-1` return 0. Kept separate so table edits do not touch the sequencer.
- Use one shared cycle counter, sized for the largest of the three count parameters.

## Test plan
- Reset released, master model ACKs every write, with `NUM_REGS=4` and `STARTUP_CYCLES=10` → exactly 4 `start` pulses carrying the `config_rom` pairs in order; `done`=1, `busy`=0, `index`=3.
- Entry 2 NACKed twice, then ACKed, with `MAX_RETRY=3` → 3 `start` pulses all carrying entry 2; the sequence then completes with `done`=1.
- Entry 1 NACKed every time, with `MAX_RETRY=3` → 4 attempts on entry 1, then `error`=1, `index`=1, and no further `start`.
- Master never pulses `i2c_done`, with `TIMEOUT_CYCLES=100` → retry issued 100 + `GAP_CYCLES` + 2 cycles after the `start`; after the retries are exhausted, `error`=1.
- `reset` pulled low during `WAIT_DONE` of entry 2 → all outputs return to reset values in the same cycle; after release, the first `start` carries entry 0.
- `go` pulsed in `FINISH`, and again pulsed in the middle of the sequence → the `FINISH` pulse restarts from entry 0 without the startup delay; the mid-sequence pulse has no effect.
